fifo_wr_arb_crgn: RTL and testbench

- Packet-aware round-robin write arbiter sharing one single-clock FIFO between NUM_REQ requesters.
- Drives the write side of the FIFO pointer controller (wr_op, full, entry_used, wr_addr) and the 1r1w compiled memory write port.
- A new packet is granted only when the FIFO can absorb a maximum-length packet, so a packet is never interleaved and never stalls mid-way.

---
 rtl/fifo_wr_arb_crgn_pkg.sv | 18 +
 rtl/fifo_wr_arb_crgn_rr_pick.sv | 36 +++
 rtl/fifo_wr_arb_crgn.sv | 162 ++++++++++++++++
 tb/tb_fifo_wr_arb_crgn.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_crgn_pkg.sv
// Shared definitions for the FIFO write arbiter (fifo_arb_defs_crgn):
// arbiter state encodings, statistics counter width and a wrap-around
// increment helper used for the round-robin pointer.
package fifo_wr_arb_crgn_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // (idx + 1) mod n for idx in [0, n-1]
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_crgn_rr_pick.sv
// rr_pick_crgn: combinational rotating-priority picker.
// Finds the first set bit of req searching start, start+1, ... mod NUM_REQ.
// Ports:
//   req    in  NUM_REQ    request vector
//   start  in  REQ_IDX_W  highest-priority index (must be < NUM_REQ)
//   found  out 1          some request is set
//   index  out REQ_IDX_W  index of the picked request (0 when !found)
module rr_pick_crgn #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] start,
    output logic                 found,
    output logic [REQ_IDX_W-1:0] index
);

    // Rotate so that bit 0 of rot corresponds to requester 'start'.
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    assign dbl = {req, req} >> start;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                index = REQ_IDX_W'((int'(start) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb_crgn.sv
// fifo_wr_arb_crgn: packet-aware round-robin write arbiter sharing one
// single-clock FIFO between NUM_REQ requesters. A packet starts only when
// the FIFO can absorb MAX_PKT_LEN beats, then owns the write port until its
// last beat, so packets are never interleaved.
// Optional build macro: FIFO_WR_ARB_STATS_EN adds per-requester beat
// counters and a stall counter (stat_sel / stat_beats / stat_stall).
// Ports:
//   clk, reset_n (sync, active-low), clr (sync clear, shared with controller)
//   req / req_last / req_data   requester beat interface
//   gnt                         combinational one-hot-or-zero beat accept
//   fifo_full, fifo_entry_used, fifo_wr_addr   from FIFO pointer controller
//   fifo_wr_op                  registered write strobe to controller
//   mem_wr_en/addr/data         1r1w memory write port
//   owner, busy                 locked requester and LOCKED indication
module fifo_wr_arb_crgn
    import fifo_wr_arb_crgn_pkg::*;
#(
    parameter int PTR_WIDTH      = 8,
    parameter int NUM_OF_ENTRIES = 256,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int REQ_IDX_W      = 2,
    parameter int MAX_PKT_LEN    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clr,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic [PTR_WIDTH:0]            fifo_entry_used,
    input  logic [PTR_WIDTH-1:0]          fifo_wr_addr,
    output logic                          fifo_wr_op,
    output logic                          mem_wr_en,
    output logic [PTR_WIDTH-1:0]          mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    output logic [REQ_IDX_W-1:0]          owner,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,input  logic [REQ_IDX_W-1:0]          stat_sel,
    output logic [STAT_W-1:0]             stat_beats,
    output logic [STAT_W-1:0]             stat_stall
`endif
);

    localparam int CW = PTR_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH  = CW'(NUM_OF_ENTRIES);
    localparam logic [CW-1:0] MAXPKT = CW'(MAX_PKT_LEN);

    logic                  rst;
    arb_state_t            state, state_nxt;
    logic [REQ_IDX_W-1:0]  rr_ptr, rr_nxt, owner_nxt;
    logic [REQ_IDX_W-1:0]  pick_idx, acc_idx;
    logic                  pick_found, acc;
    logic [CW-1:0]         used, free_eff;
    logic                  start_ok, beat_ok;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    assign rst = !reset_n || clr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Occupancy as seen by the arbiter: the write in flight has not yet
    // moved the controller's pointer, so it is charged here.
    assign used     = fifo_entry_used[PTR_WIDTH] ? DEPTH
                                                 : {2'b00, fifo_entry_used[PTR_WIDTH-1:0]};
    assign free_eff = DEPTH - used - {{(CW-1){1'b0}}, fifo_wr_op};
    assign start_ok = (free_eff >= MAXPKT);
    assign beat_ok  = (free_eff != '0) && !fifo_full;

    rr_pick_crgn #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_pick (
        .req   (req),
        .start (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        gnt       = '0;
        acc       = 1'b0;
        acc_idx   = owner;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        case (state)
            ARB_IDLE: begin
                if (pick_found && start_ok) begin
                    gnt[pick_idx] = 1'b1;
                    acc           = 1'b1;
                    acc_idx       = pick_idx;
                    if (req_last[pick_idx]) begin
                        rr_nxt = REQ_IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
                    end else begin
                        state_nxt = ARB_LOCKED;
                        owner_nxt = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (req[owner] && beat_ok) begin
                    gnt[owner] = 1'b1;
                    acc        = 1'b1;
                    if (req_last[owner]) begin
                        state_nxt = ARB_IDLE;
                        rr_nxt    = REQ_IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (rst) begin
            gnt = '0;
            acc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            fifo_wr_op  <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            owner      <= owner_nxt;
            fifo_wr_op <= acc;
            if (acc) mem_wr_data <= data_arr[acc_idx];
        end
    end

    assign busy        = (state == ARB_LOCKED);
    assign mem_wr_en   = fifo_wr_op;
    assign mem_wr_addr = fifo_wr_addr;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] beat_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) beat_cnt[i] <= '0;
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (acc && beat_cnt[acc_idx] != '1)
                beat_cnt[acc_idx] <= beat_cnt[acc_idx] + 1'b1;
            if ((|req) && !(|gnt) && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
            stat_beats <= (int'(stat_sel) < NUM_REQ) ? beat_cnt[stat_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb_crgn.sv
// Directed bench for fifo_wr_arb_crgn. A small FIFO pointer controller model
// (occupancy, write pointer, full) is kept in the stimulus process and
// updated once per clock from the DUT write strobe and the bench read strobe.
module tb_fifo_wr_arb_crgn;

    logic         clk = 1'b0;
    logic         reset_n, clr;
    logic [3:0]   req, req_last, gnt;
    logic [127:0] req_data;
    logic         fifo_full;
    logic [8:0]   fifo_entry_used;
    logic [7:0]   fifo_wr_addr;
    logic         fifo_wr_op, mem_wr_en;
    logic [7:0]   mem_wr_addr;
    logic [31:0]  mem_wr_data;
    logic [1:0]   owner;
    logic         busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [1:0]   stat_sel = 2'd0;
    logic [15:0]  stat_beats, stat_stall;
`endif

    int   used, wptr, ntests, nfail, beats, bad;
    logic rd, g;

    always #5 clk = ~clk;

    fifo_wr_arb_crgn dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clr             (clr),
        .req             (req),
        .req_last        (req_last),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_full       (fifo_full),
        .fifo_entry_used (fifo_entry_used),
        .fifo_wr_addr    (fifo_wr_addr),
        .fifo_wr_op      (fifo_wr_op),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .owner           (owner),
        .busy            (busy)
`ifdef FIFO_WR_ARB_STATS_EN
       ,.stat_sel        (stat_sel),
        .stat_beats      (stat_beats),
        .stat_stall      (stat_stall)
`endif
    );

    task automatic drive_fifo();
        fifo_entry_used = 9'(used);
        fifo_full       = (used == 256);
        fifo_wr_addr    = 8'(wptr);
    endtask

    // One clock: the controller model absorbs the strobe and read seen
    // during the cycle, then outputs are re-driven 1 ns after the edge.
    task automatic tick();
        logic w, r, c;
        w = fifo_wr_op;
        r = rd && (used > 0);
        c = clr || !reset_n;
        @(posedge clk);
        #1;
        if (c) begin
            used = 0;
            wptr = 0;
        end else begin
            used = used + int'(w) - int'(r);
            wptr = (wptr + int'(w)) % 256;
        end
        drive_fifo();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        ntests = 0; nfail = 0; used = 0; wptr = 0; rd = 1'b0;
        reset_n = 1'b0; clr = 1'b0;
        req = '0; req_last = '0; req_data = '0;
        drive_fifo();

        // ---------------- reset state
        tick(); tick();
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_wrop",  32'(fifo_wr_op), 32'h0);
        chk("rst_wren",  32'(mem_wr_en), 32'h0);
        chk("rst_data",  mem_wr_data, 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();

        // ---------------- single-beat fairness: 0,1,2,3,0
        req = 4'hF; req_last = 4'hF;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_gnt", 32'(gnt), 32'(1) << (k % 4));
            tick();
            chk("fair_wrop", 32'(fifo_wr_op), 32'h1);
            chk("fair_data", mem_wr_data, 32'h1000_0000 + 32'(k % 4));
            chk("fair_addr", 32'(mem_wr_addr), 32'(k));
        end
        req = '0;
        do_clr();

        // ---------------- packet lock: req0 3 beats, req1 waiting
        req = 4'b0011; req_last = 4'b0010;
        req_data[31:0] = 32'hA0; req_data[63:32] = 32'hB1;
        #1 chk("lock_b1", 32'(gnt), 32'h1);
        tick();
        chk("lock_busy",  32'(busy), 32'h1);
        chk("lock_owner", 32'(owner), 32'h0);
        chk("lock_d1",    mem_wr_data, 32'hA0);
        req_data[31:0] = 32'hA1;
        #1 chk("lock_b2", 32'(gnt), 32'h1);
        tick();
        req_data[31:0] = 32'hA2; req_last = 4'b0011;
        #1 chk("lock_b3", 32'(gnt), 32'h1);
        tick();
        chk("lock_end_busy", 32'(busy), 32'h0);
        chk("lock_d3",       mem_wr_data, 32'hA2);
        req = 4'b0010;
        #1 chk("lock_next", 32'(gnt), 32'h2);
        tick();

        // ---------------- reset mid-packet (owner 2, rr_ptr 2 before reset)
        req = 4'b0100; req_last = 4'b0000; req_data[95:64] = 32'hC2;
        #1 chk("mid_gnt", 32'(gnt), 32'h4);
        tick();
        chk("mid_owner", 32'(owner), 32'h2);
        chk("mid_busy",  32'(busy), 32'h1);
        reset_n = 1'b0; req = 4'hF; req_last = 4'hF;
        #1 chk("mid_rst_gnt", 32'(gnt), 32'h0);
        tick();
        chk("mid_rst_busy",  32'(busy), 32'h0);
        chk("mid_rst_wrop",  32'(fifo_wr_op), 32'h0);
        chk("mid_rst_owner", 32'(owner), 32'h0);
        reset_n = 1'b1;
        #1 chk("mid_rst_rr", 32'(gnt), 32'h1);
        req = '0;
        do_clr();

        // ---------------- start threshold (256 entries, MAX_PKT_LEN 16)
        used = 240; drive_fifo();
        req = 4'b0001; req_last = 4'b0001;
        #1 chk("thr_240_start", 32'(gnt), 32'h1);
        tick();                       // used 240 + write in flight
        #1 chk("thr_inflight", 32'(gnt), 32'h0);
        tick();                       // used 241
        chk("thr_used", 32'(fifo_entry_used), 32'd241);
        #1 chk("thr_241", 32'(gnt), 32'h0);
        rd = 1'b1; tick(); rd = 1'b0; // drain to 240
        #1 chk("thr_drain", 32'(gnt), 32'h1);
        req = '0;
        do_clr();

        // ---------------- full boundary: one single beat first (rr_ptr -> 1)
        req = 4'b0001; req_last = 4'b0001; req_data[31:0] = 32'h55;
        #1 chk("pre_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;
        tick();
        rd = 1'b1; tick(); rd = 1'b0; // FIFO empty, wr pointer at 1

        req = 4'b1000; req_last = 4'b0000;
        beats = 0; bad = 0;
        for (int c = 0; c < 262; c++) begin
            req_data[127:96] = 32'h3000_0000 + 32'(beats);
            #1;
            g = gnt[3];
            if (gnt[2:0] != 3'b000) bad++;
            if (fifo_wr_op && fifo_full) bad++;
            tick();
            if (g) beats++;
        end
        chk("full_beats", 32'(beats), 32'd256);
        chk("full_bad",   32'(bad), 32'd0);
        chk("full_flag",  32'(fifo_full), 32'h1);
        chk("full_wrop",  32'(fifo_wr_op), 32'h0);
        #1 chk("full_gnt", 32'(gnt), 32'h0);
        rd = 1'b1; tick(); rd = 1'b0;
        #1 chk("full_read1", 32'(gnt), 32'h8);
        tick();
        chk("full_r_wrop", 32'(fifo_wr_op), 32'h1);
        chk("full_r_addr", 32'(mem_wr_addr), 32'h1);
        chk("full_r_data", mem_wr_data, 32'h3000_0100);
        #1 chk("full_one_beat", 32'(gnt), 32'h0);

        // ---------------- clr mid-packet (a beat would be granted otherwise)
        rd = 1'b1; tick(); rd = 1'b0;
        clr = 1'b1;
        #1 chk("clr_gnt", 32'(gnt), 32'h0);
        tick();
        clr = 1'b0;
        chk("clr_busy",  32'(busy), 32'h0);
        chk("clr_wrop",  32'(fifo_wr_op), 32'h0);
        chk("clr_owner", 32'(owner), 32'h0);
        req = 4'b1001; req_last = 4'b1001; req_data[31:0] = 32'hD0;
        #1 chk("clr_newpkt", 32'(gnt), 32'h1);
        tick();
        chk("clr_data", mem_wr_data, 32'hD0);
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
